// File: rtl/asap_mac_seq.sv
// asap_mac_seq: LOAD/EXEC/ACC scheduled datapath that reduces DEPTH operand pairs to one result.
// Rev 1.0 - go/done/CS control contract with an in_valid/in_ready operand handshake.
`default_nettype none

module asap_mac_seq #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out,
  output logic [2:0]           CS,
  output logic                 done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH-1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                 state;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       r1;
  logic [WIDTH-1:0]       r2;
  logic [2*WIDTH-1:0]     r3;
  logic [ACC_WIDTH-1:0]   acc;

  logic [2*WIDTH-1:0]     term;
  logic [ACC_WIDTH-1:0]   r3_ext;
  logic [ACC_WIDTH-1:0]   acc_next;

  // Every term is at most 2*WIDTH bits wide, so zero-extension is lossless.
  always_comb begin
    term = '0;
    case (mode_q)
      2'd1:    term = (r1 >= r2) ? {{WIDTH{1'b0}}, r1 - r2} : {{WIDTH{1'b0}}, r2 - r1};
      2'd3:    term = {{(WIDTH-1){1'b0}}, {1'b0, r1} + {1'b0, r2}};
      default: term = {{WIDTH{1'b0}}, r1} * {{WIDTH{1'b0}}, r2};
    endcase
  end

  always_comb begin
    r3_ext   = ACC_WIDTH'(r3);
    acc_next = acc + r3_ext;
    if (mode_q == 2'd2) begin
      acc_next = (r3_ext > acc) ? r3_ext : acc;
    end
  end

  assign in_ready = (state == LOAD);
  assign CS       = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode_q <= 2'd0;
      cnt    <= '0;
      r1     <= '0;
      r2     <= '0;
      r3     <= '0;
      acc    <= '0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            acc    <= '0;
            cnt    <= '0;
            mode_q <= mode;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r1    <= in0;
            r2    <= in1;
            state <= EXEC;
          end
        end
        EXEC: begin
          r3    <= term;
          state <= ACC;
        end
        ACC: begin
          acc <= acc_next;
          if (cnt == LAST) begin
            out   <= acc_next;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_asap_mac_seq.sv
// Scoreboard bench for asap_mac_seq: directed operand vectors, expected results queued at go time.
`default_nettype none

module tb_asap_mac_seq;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2*WIDTH + $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            go = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [WIDTH-1:0] in0 = '0;
  logic [WIDTH-1:0] in1 = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [AW-1:0]   out;
  logic [2:0]      CS;
  logic            done;

  asap_mac_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .in0(in0), .in1(in1),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .CS(CS), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0]   exp_val[$];
  int              exp_cyc[$];
  logic [2:0]      trace[$];
  bit              trace_on = 0;
  logic [WIDTH-1:0] av[4];
  logic [WIDTH-1:0] bv[4];
  int              stall[4];
  bit              poke = 0;
  logic [AW-1:0]   prev_out;
  logic [AW-1:0]   mon_val;
  int              mon_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout, expected DUT progress", name);
  endtask

  // Monitor: every done pulse is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (rst && done === 1'b1) begin
      if (exp_val.size() == 0) begin
        fail_now("spurious_done");
      end else begin
        mon_val = exp_val.pop_front();
        mon_cyc = exp_cyc.pop_front();
        check("result", 64'(out), 64'(mon_val));
        check("latency", 64'(cyc), 64'(mon_cyc));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (trace_on) trace.push_back(CS);
  end

  task automatic run_op(input logic [1:0] m, input logic [AW-1:0] ev);
    int tot;
    int w;
    tot = 0;
    foreach (stall[i]) tot += stall[i];
    @(negedge clk);
    go   = 1'b1;
    mode = m;
    exp_val.push_back(ev);
    exp_cyc.push_back(cyc + 3*DEPTH + 1 + tot);
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
        @(negedge clk);
        go = 1'b0;
        w++;
      end
      if (w >= 50) fail_now("load_wait");
      for (int s = 0; s < stall[i]; s++) begin
        check("stall_in_ready", 64'(in_ready), 64'd1);
        check("stall_cs", 64'(CS), 64'd1);
        @(negedge clk);
      end
      in0      = av[i];
      in1      = bv[i];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (poke && i == 1) begin
        check("out_hold", 64'(out), 64'(prev_out));
        go   = 1'b1;
        mode = ~m;
      end
    end
    w = 0;
    while (exp_val.size() != 0 && w < 40) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (w >= 40) begin
      fail_now("done_wait");
      exp_val.delete();
      exp_cyc.delete();
    end
  endtask

  logic [2:0] exp_tr[15];
  int acc_seen;
  int w0;

  initial begin
    exp_tr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3,
               3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    stall = '{0, 0, 0, 0};

    repeat (3) @(negedge clk);
    check("rst_cs", 64'(CS), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Sum of products with the CS trace recorded.
    av = '{8'd1, 8'd3, 8'd5, 8'd7};
    bv = '{8'd2, 8'd4, 8'd6, 8'd8};
    @(negedge clk);
    trace_on = 1;
    run_op(2'd0, 100);
    trace_on = 0;
    check("trace_len", 64'(trace.size()), 64'd15);
    for (int i = 0; i < 15 && i < trace.size(); i++) check("cs_trace", 64'(trace[i]), 64'(exp_tr[i]));

    av = '{8'd10, 8'd3, 8'd0, 8'd7};
    bv = '{8'd3, 8'd10, 8'd255, 8'd7};
    run_op(2'd1, 269);

    av = '{8'd15, 8'd255, 8'd2, 8'd0};
    bv = '{8'd15, 8'd255, 8'd3, 8'd9};
    run_op(2'd2, 65025);

    av = '{8'd255, 8'd255, 8'd255, 8'd255};
    bv = '{8'd255, 8'd255, 8'd255, 8'd255};
    run_op(2'd3, 2040);
    run_op(2'd0, 260100);

    // Backpressure before the second pair.
    av = '{8'd1, 8'd3, 8'd5, 8'd7};
    bv = '{8'd2, 8'd4, 8'd6, 8'd8};
    stall = '{0, 5, 0, 0};
    run_op(2'd0, 100);
    stall = '{0, 0, 0, 0};

    // go pulse in EXEC and mode pin flip: latched sum-of-sums still applies.
    prev_out = 100;
    poke = 1;
    run_op(2'd3, 36);
    poke = 0;

    // Reset during the second ACC.
    @(negedge clk);
    go = 1'b1; mode = 2'd0; in0 = 8'd1; in1 = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    go = 1'b0;
    acc_seen = 0;
    w0 = 0;
    while (acc_seen < 2 && w0 < 40) begin
      if (CS == 3'd3) acc_seen++;
      if (acc_seen < 2) @(negedge clk);
      w0++;
    end
    if (acc_seen < 2) fail_now("reach_acc");
    rst = 1'b0;
    #1;
    check("midrst_cs", 64'(CS), 64'd0);
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    av = '{8'd1, 8'd1, 8'd1, 8'd1};
    bv = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_op(2'd0, 4);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_val.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
